// File: rtl/gpgpu_pkg.sv
// Shared GPGPU definitions: dispatcher state encoding, arbitration modes
// and the MP-id width helper.
package gpgpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dispatch_state_e;

  localparam int ARB_RR = 0;
  localparam int ARB_LL = 1;

  // A single MP still needs a one-bit id.
  function automatic int mpid_depth(input int num_mps);
    return (num_mps > 1) ? $clog2(num_mps) : 1;
  endfunction

endpackage

// File: rtl/mp_select.sv
// Combinational target-MP picker: round-robin from rr_ptr, or least-loaded
// with ties going to the lowest index.
module mp_select
  import gpgpu_pkg::*;
#(
  parameter  int NUM_MPS    = 8,
  parameter  int OCC_WIDTH  = 3,
  parameter  int ARB_MODE   = ARB_RR,
  localparam int MPID_DEPTH = mpid_depth(NUM_MPS)
) (
  input  logic [NUM_MPS-1:0]    eligible,
  input  logic [OCC_WIDTH-1:0]  occ [NUM_MPS],
  input  logic [MPID_DEPTH-1:0] rr_ptr,
  output logic [MPID_DEPTH-1:0] sel,
  output logic                  any_eligible
);

  logic [MPID_DEPTH-1:0] rr_sel;
  logic [MPID_DEPTH-1:0] ll_sel;
  logic [OCC_WIDTH-1:0]  ll_best;
  logic                  rr_found;
  logic                  ll_found;

  // Two passes give the wrap: first MPs at/after rr_ptr, then the rest.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_MPS; i++) begin
      if (!rr_found && eligible[i] && (i >= int'(rr_ptr))) begin
        rr_found = 1'b1;
        rr_sel   = MPID_DEPTH'(i);
      end
    end
    for (int i = 0; i < NUM_MPS; i++) begin
      if (!rr_found && eligible[i]) begin
        rr_found = 1'b1;
        rr_sel   = MPID_DEPTH'(i);
      end
    end
  end

  // Strict less-than keeps the lowest index on equal occupancy.
  always_comb begin
    ll_sel   = '0;
    ll_best  = '0;
    ll_found = 1'b0;
    for (int i = 0; i < NUM_MPS; i++) begin
      if (eligible[i] && (!ll_found || (occ[i] < ll_best))) begin
        ll_found = 1'b1;
        ll_best  = occ[i];
        ll_sel   = MPID_DEPTH'(i);
      end
    end
  end

  assign sel          = (ARB_MODE == ARB_LL) ? ll_sel : rr_sel;
  assign any_eligible = |eligible;

endmodule

// File: rtl/block_dispatcher.sv
// Hands thread blocks from the global scheduler to individual MPs, tracks
// per-MP residency and per-kernel progress, and signals kernel completion.
module block_dispatcher
  import gpgpu_pkg::*;
#(
  parameter  int NUM_MPS       = 8,
  parameter  int NUM_BLOCKS    = 4,
  parameter  int GRID_DIM      = 32,
  parameter  int NUM_WARPS     = 16,
  parameter  int BLK_CNT_WIDTH = 16,
  parameter  int ARB_MODE      = ARB_RR,
  localparam int MPID_DEPTH    = mpid_depth(NUM_MPS),
  localparam int OCC_WIDTH     = $clog2(NUM_BLOCKS + 1),
  localparam int WARPID_DEPTH  = $clog2(NUM_WARPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     kernel_start,
  input  logic [BLK_CNT_WIDTH-1:0] kernel_num_blocks,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic [GRID_DIM-1:0]      blk_bidx,
  input  logic [WARPID_DEPTH-1:0]  blk_warps,
  input  logic [NUM_MPS-1:0]       mp_ready,
  input  logic [NUM_MPS-1:0]       mp_done,
  output logic                     start,
  output logic [MPID_DEPTH-1:0]    mpid,
  output logic [GRID_DIM-1:0]      bidx,
  output logic [WARPID_DEPTH-1:0]  warp_o,
  output logic                     kernel_done,
  output logic                     busy_o,
  output logic                     err_o
);

  dispatch_state_e            state_q, state_d;
  logic [OCC_WIDTH-1:0]       occ_q [NUM_MPS];
  logic [OCC_WIDTH-1:0]       occ_d [NUM_MPS];
  logic [BLK_CNT_WIDTH-1:0]   total_q, total_d;
  logic [BLK_CNT_WIDTH-1:0]   issued_q, issued_d;
  logic [BLK_CNT_WIDTH-1:0]   retired_q, retired_d;
  logic [BLK_CNT_WIDTH-1:0]   done_cnt;
  logic [MPID_DEPTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [MPID_DEPTH-1:0]      mpid_q, mpid_d;
  logic [GRID_DIM-1:0]        bidx_q, bidx_d;
  logic [WARPID_DEPTH-1:0]    warp_q, warp_d;
  logic                       start_q, start_d;
  logic                       err_q, err_d;
  logic [NUM_MPS-1:0]         eligible;
  logic [MPID_DEPTH-1:0]      sel;
  logic                       any_eligible;
  logic                       accept;
  logic                       occ_any;

  always_comb begin
    eligible = '0;
    occ_any  = 1'b0;
    for (int i = 0; i < NUM_MPS; i++) begin
      eligible[i] = mp_ready[i] && (occ_q[i] < OCC_WIDTH'(NUM_BLOCKS));
      occ_any     = occ_any || (occ_q[i] != '0);
    end
  end

  mp_select #(
    .NUM_MPS   (NUM_MPS),
    .OCC_WIDTH (OCC_WIDTH),
    .ARB_MODE  (ARB_MODE)
  ) u_mp_select (
    .eligible     (eligible),
    .occ          (occ_q),
    .rr_ptr       (rr_ptr_q),
    .sel          (sel),
    .any_eligible (any_eligible)
  );

  assign blk_ready = (state_q == RUN) && (issued_q < total_q) && any_eligible;
  assign accept    = blk_valid && blk_ready;

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    issued_d  = issued_q;
    rr_ptr_d  = rr_ptr_q;
    start_d   = 1'b0;
    mpid_d    = mpid_q;
    bidx_d    = bidx_q;
    warp_d    = warp_q;
    err_d     = err_q;
    done_cnt  = '0;

    // A done on an empty MP is a protocol error and is not counted.
    for (int i = 0; i < NUM_MPS; i++) begin
      occ_d[i] = occ_q[i]
               + OCC_WIDTH'(accept && (sel == MPID_DEPTH'(i)))
               - OCC_WIDTH'(mp_done[i] && (occ_q[i] != '0));
      done_cnt = done_cnt + BLK_CNT_WIDTH'(mp_done[i] && (occ_q[i] != '0));
      if (mp_done[i] && (occ_q[i] == '0)) begin
        err_d = 1'b1;
      end
    end
    retired_d = retired_q + done_cnt;

    if (accept) begin
      start_d  = 1'b1;
      mpid_d   = sel;
      bidx_d   = blk_bidx;
      warp_d   = blk_warps;
      issued_d = issued_q + 1'b1;
      rr_ptr_d = (sel == MPID_DEPTH'(NUM_MPS - 1)) ? '0 : sel + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (kernel_start) begin
          state_d = RUN;
          total_d = kernel_num_blocks;
        end
      end
      RUN: begin
        if (retired_q == total_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        issued_d  = '0;
        retired_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      total_q   <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      rr_ptr_q  <= '0;
      start_q   <= 1'b0;
      mpid_q    <= '0;
      bidx_q    <= '0;
      warp_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_MPS; i++) begin
        occ_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      rr_ptr_q  <= rr_ptr_d;
      start_q   <= start_d;
      mpid_q    <= mpid_d;
      bidx_q    <= bidx_d;
      warp_q    <= warp_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_MPS; i++) begin
        occ_q[i] <= occ_d[i];
      end
    end
  end

  assign start       = start_q;
  assign mpid        = mpid_q;
  assign bidx        = bidx_q;
  assign warp_o      = warp_q;
  assign kernel_done = (state_q == DONE);
  assign busy_o      = (state_q != IDLE) || occ_any;
  assign err_o       = err_q;

endmodule
